// File: rtl/ecc_mem_pkg.sv
// Shared SECDED definitions: codeword width, read/write response codes and the encoder.
// Codeword layout: bit 0 = overall parity, bits 1..38 = Hamming(38,32) with check bits at powers of two.
package ecc_mem_pkg;
  localparam int CW_WIDTH = 39;
  localparam int DW       = 32;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_CORR   = 2'b01,
    RESP_UNCORR = 2'b10,
    RESP_SLVERR = 2'b11
  } resp_e;

  function automatic logic [CW_WIDTH-1:0] secded_encode(input logic [DW-1:0] data);
    logic [CW_WIDTH-1:0] cw;
    int d;
    cw = '0;
    d  = 0;
    for (int i = 1; i < CW_WIDTH; i++) begin
      if ((i & (i - 1)) != 0) begin
        cw[i] = data[d];
        d++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      for (int i = 1; i < CW_WIDTH; i++) begin
        if (((i & (1 << k)) != 0) && ((i & (i - 1)) != 0)) cw[1 << k] ^= cw[i];
      end
    end
    cw[0] = ^cw[CW_WIDTH-1:1];
    return cw;
  endfunction
endpackage

// File: rtl/ecc_mem_ctrl_if.sv
// Write/read request and response bundle between a client (master) and ecc_mem_ctrl (slave).
interface ecc_mem_ctrl_if #(
  parameter int DATA_WIDTH          = 32,
  parameter int MEM_CTRL_ADDR_WIDTH = 14
);
  logic                           ECC_ctrl_wr_en;
  logic [MEM_CTRL_ADDR_WIDTH-1:0] ECC_ctrl_wr_addr_bus;
  logic [DATA_WIDTH-1:0]          ECC_ctrl_write_data_bus;
  logic [1:0]                     wr_resp;
  logic                           ECC_ctrl_rd_en;
  logic [MEM_CTRL_ADDR_WIDTH-1:0] ECC_ctrl_rd_addr_bus;
  logic [DATA_WIDTH-1:0]          ECC_ctrl_data_out;
  logic                           rd_valid;
  logic [1:0]                     rd_resp;
  logic [15:0]                    sbe_count;
  logic [15:0]                    dbe_count;

  modport master (
    output ECC_ctrl_wr_en, ECC_ctrl_wr_addr_bus, ECC_ctrl_write_data_bus,
    output ECC_ctrl_rd_en, ECC_ctrl_rd_addr_bus,
    input  wr_resp, ECC_ctrl_data_out, rd_valid, rd_resp, sbe_count, dbe_count
  );

  modport slave (
    input  ECC_ctrl_wr_en, ECC_ctrl_wr_addr_bus, ECC_ctrl_write_data_bus,
    input  ECC_ctrl_rd_en, ECC_ctrl_rd_addr_bus,
    output wr_resp, ECC_ctrl_data_out, rd_valid, rd_resp, sbe_count, dbe_count
  );
endinterface

// File: rtl/secded_decoder.sv
// Combinational SECDED syndrome decode and single-bit correction of a 39-bit codeword.
module secded_decoder
  import ecc_mem_pkg::*;
(
  input  logic [CW_WIDTH-1:0] i_cw,
  output logic [DW-1:0]       o_data,
  output resp_e               o_status
);
  logic [5:0]          w_syn;
  logic                w_par;
  logic [CW_WIDTH-1:0] w_fix;

  always_comb begin
    int d;
    w_syn    = '0;
    w_par    = ^i_cw;
    w_fix    = i_cw;
    o_status = RESP_OKAY;
    o_data   = '0;
    d        = 0;
    for (int i = 1; i < CW_WIDTH; i++) begin
      if (i_cw[i]) w_syn = w_syn ^ 6'(i);
    end
    // Odd overall parity means one flipped bit; syndrome 0 points at the parity bit itself.
    if (w_par) begin
      o_status = RESP_CORR;
      if (w_syn != 6'd0) begin
        if (w_syn < 6'd39) w_fix[w_syn] = ~i_cw[w_syn];
        else               o_status     = RESP_UNCORR;
      end
    end else if (w_syn != 6'd0) begin
      o_status = RESP_UNCORR;
    end
    for (int i = 1; i < CW_WIDTH; i++) begin
      if ((i & (i - 1)) != 0) begin
        o_data[d] = w_fix[i];
        d++;
      end
    end
  end
endmodule

// File: rtl/ecc_mem_ctrl.sv
// SECDED-protected word memory with 2-cycle pipelined reads and error counters.
// Optional corrected-data write-back is enabled by defining ECC_MEM_CTRL_SCRUB_EN.
module ecc_mem_ctrl
  import ecc_mem_pkg::*;
#(
  parameter int DATA_WIDTH          = 32,
  parameter int MEM_CTRL_ADDR_WIDTH = 14,
  parameter int EXT_MEM_DEPTH       = 1024
) (
  input logic          clk,
  input logic          reset,
  ecc_mem_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(EXT_MEM_DEPTH);
  localparam logic [MEM_CTRL_ADDR_WIDTH-1:0] DEPTH_A = MEM_CTRL_ADDR_WIDTH'(EXT_MEM_DEPTH);

  logic [CW_WIDTH-1:0]   r_mem [EXT_MEM_DEPTH];
  logic                  r_s1_valid, r_s1_oor;
  logic [CW_WIDTH-1:0]   r_s1_cw;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_data_out;
  resp_e                 r_rd_resp, r_wr_resp;
  logic [15:0]           r_sbe_count, r_dbe_count;

  logic                  w_wr_ok, w_rd_in;
  logic [IDX_W-1:0]      w_wr_idx, w_rd_idx;
  logic [DW-1:0]         w_dec_data;
  resp_e                 w_dec_status;

  assign w_wr_ok  = bus.ECC_ctrl_wr_en && (bus.ECC_ctrl_wr_addr_bus < DEPTH_A);
  assign w_rd_in  = bus.ECC_ctrl_rd_addr_bus < DEPTH_A;
  assign w_wr_idx = bus.ECC_ctrl_wr_addr_bus[IDX_W-1:0];
  assign w_rd_idx = bus.ECC_ctrl_rd_addr_bus[IDX_W-1:0];

`ifdef ECC_MEM_CTRL_SCRUB_EN
  logic                r_scrub_pend, r_s1_stale;
  logic [IDX_W-1:0]    r_scrub_idx, r_s1_idx;
  logic [CW_WIDTH-1:0] r_scrub_cw;
  logic                w_new_err, w_scrub_go;

  assign w_new_err  = r_s1_valid && !r_s1_oor && (w_dec_status == RESP_CORR) && !r_s1_stale;
  assign w_scrub_go = r_scrub_pend && !bus.ECC_ctrl_wr_en && !reset;

  // An external write to the scrub target makes the buffered correction stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scrub_pend <= 1'b0;
      r_scrub_idx  <= '0;
      r_scrub_cw   <= '0;
      r_s1_idx     <= '0;
      r_s1_stale   <= 1'b0;
    end else begin
      r_s1_idx   <= w_rd_idx;
      r_s1_stale <= w_wr_ok && bus.ECC_ctrl_rd_en && w_rd_in && (w_wr_idx == w_rd_idx);
      if (w_new_err) begin
        r_scrub_pend <= !(w_wr_ok && (w_wr_idx == r_s1_idx));
        r_scrub_idx  <= r_s1_idx;
        r_scrub_cw   <= secded_encode(w_dec_data);
      end else if (w_scrub_go || (w_wr_ok && (w_wr_idx == r_scrub_idx))) begin
        r_scrub_pend <= 1'b0;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[w_wr_idx] <= secded_encode(bus.ECC_ctrl_write_data_bus);
`ifdef ECC_MEM_CTRL_SCRUB_EN
    else if (w_scrub_go) r_mem[r_scrub_idx] <= r_scrub_cw;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_oor   <= 1'b0;
      r_s1_cw    <= '0;
    end else begin
      r_s1_valid <= bus.ECC_ctrl_rd_en;
      r_s1_oor   <= !w_rd_in;
      if (bus.ECC_ctrl_rd_en) r_s1_cw <= w_rd_in ? r_mem[w_rd_idx] : '0;
    end
  end

  secded_decoder u_dec (
    .i_cw     (r_s1_cw),
    .o_data   (w_dec_data),
    .o_status (w_dec_status)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid  <= 1'b0;
      r_data_out  <= '0;
      r_rd_resp   <= RESP_OKAY;
      r_wr_resp   <= RESP_OKAY;
      r_sbe_count <= '0;
      r_dbe_count <= '0;
    end else begin
      r_rd_valid <= r_s1_valid;
      r_wr_resp  <= (bus.ECC_ctrl_wr_en && !w_wr_ok) ? RESP_SLVERR : RESP_OKAY;
      if (r_s1_valid) begin
        if (r_s1_oor) begin
          r_data_out <= '0;
          r_rd_resp  <= RESP_SLVERR;
        end else begin
          r_data_out <= w_dec_data;
          r_rd_resp  <= w_dec_status;
          if (w_dec_status == RESP_CORR && r_sbe_count != 16'hFFFF)
            r_sbe_count <= r_sbe_count + 16'd1;
          if (w_dec_status == RESP_UNCORR && r_dbe_count != 16'hFFFF)
            r_dbe_count <= r_dbe_count + 16'd1;
        end
      end
    end
  end

  assign bus.rd_valid          = r_rd_valid;
  assign bus.ECC_ctrl_data_out = r_data_out;
  assign bus.rd_resp           = r_rd_resp;
  assign bus.wr_resp           = r_wr_resp;
  assign bus.sbe_count         = r_sbe_count;
  assign bus.dbe_count         = r_dbe_count;
endmodule

// File: tb/tb_ecc_mem_ctrl.sv
// Bench for ecc_mem_ctrl: vector table of write/corrupt/read cases plus pipelining, RBW, saturation and reset sequences.
module tb_ecc_mem_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [15:0] exp_sbe = 16'd0;
  logic [15:0] exp_dbe = 16'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ecc_mem_ctrl_if #(.DATA_WIDTH(32), .MEM_CTRL_ADDR_WIDTH(14)) bus ();

  ecc_mem_ctrl #(.DATA_WIDTH(32), .MEM_CTRL_ADDR_WIDTH(14), .EXT_MEM_DEPTH(1024)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          cyc;
  } exp_t;
  exp_t q[$];

  typedef struct {
    bit          do_wr;
    logic [13:0] addr;
    logic [31:0] data;
    logic [38:0] flip;
    logic [1:0]  exp_wr;
    logic [1:0]  exp_rr;
    logic [31:0] exp_d;
  } vec_t;
  vec_t vt[13];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_rd_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rd_latency", 32'(cyc - e.cyc), 32'd2);
        chk("rd_data", bus.ECC_ctrl_data_out, e.data);
        chk("rd_resp", {30'd0, bus.rd_resp}, {30'd0, e.resp});
        if (e.resp == 2'b01 && exp_sbe != 16'hFFFF) exp_sbe = exp_sbe + 16'd1;
        if (e.resp == 2'b10 && exp_dbe != 16'hFFFF) exp_dbe = exp_dbe + 16'd1;
        chk("sbe_count", {16'd0, bus.sbe_count}, {16'd0, exp_sbe});
        chk("dbe_count", {16'd0, bus.dbe_count}, {16'd0, exp_dbe});
      end
    end
  end

  task automatic do_wr(input logic [13:0] a, input logic [31:0] d, input logic [1:0] exp_resp);
    @(negedge clk);
    bus.ECC_ctrl_wr_en = 1'b1;
    bus.ECC_ctrl_wr_addr_bus = a;
    bus.ECC_ctrl_write_data_bus = d;
    @(negedge clk);
    bus.ECC_ctrl_wr_en = 1'b0;
    chk("wr_resp", {30'd0, bus.wr_resp}, {30'd0, exp_resp});
  endtask

  task automatic corrupt(input int idx, input logic [38:0] mask);
    u_dut.r_mem[idx] = u_dut.r_mem[idx] ^ mask;
  endtask

  task automatic do_rd(input logic [13:0] a, input logic [31:0] d, input logic [1:0] r);
    @(negedge clk);
    bus.ECC_ctrl_rd_en = 1'b1;
    bus.ECC_ctrl_rd_addr_bus = a;
    q.push_back('{data: d, resp: r, cyc: cyc});
    @(negedge clk);
    bus.ECC_ctrl_rd_en = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.ECC_ctrl_wr_en = 1'b0;
    bus.ECC_ctrl_wr_addr_bus = '0;
    bus.ECC_ctrl_write_data_bus = '0;
    bus.ECC_ctrl_rd_en = 1'b0;
    bus.ECC_ctrl_rd_addr_bus = '0;

    vt[0]  = '{1'b1, 14'd5,    32'hDEADBEEF, 39'd0,                          2'b00, 2'b00, 32'hDEADBEEF};
    vt[1]  = '{1'b1, 14'd5,    32'hDEADBEEF, (39'd1 << 7),                   2'b00, 2'b01, 32'hDEADBEEF};
    vt[2]  = '{1'b1, 14'd9,    32'hCAFEF00D, (39'd1 << 3) | (39'd1 << 20),   2'b00, 2'b10, 32'hCAFEB00C};
    vt[3]  = '{1'b1, 14'd12,   32'h00000000, 39'd1,                          2'b00, 2'b01, 32'h00000000};
    vt[4]  = '{1'b1, 14'd13,   32'hFFFFFFFF, (39'd1 << 1),                   2'b00, 2'b01, 32'hFFFFFFFF};
    vt[5]  = '{1'b1, 14'd14,   32'h12345678, (39'd1 << 38),                  2'b00, 2'b01, 32'h12345678};
    vt[6]  = '{1'b1, 14'd20,   32'h5A5A5A5A, (39'd1 << 37) | 39'd1,          2'b00, 2'b10, 32'h1A5A5A5A};
    vt[7]  = '{1'b1, 14'd30,   32'h76543210, (39'd1 << 32),                  2'b00, 2'b01, 32'h76543210};
    vt[8]  = '{1'b1, 14'd1023, 32'hA5A5A5A5, 39'd0,                          2'b00, 2'b00, 32'hA5A5A5A5};
    vt[9]  = '{1'b1, 14'd0,    32'h0F0F0F0F, 39'd0,                          2'b00, 2'b00, 32'h0F0F0F0F};
    vt[10] = '{1'b1, 14'd1024, 32'h11111111, 39'd0,                          2'b11, 2'b11, 32'h00000000};
    vt[11] = '{1'b0, 14'd0,    32'h00000000, 39'd0,                          2'b00, 2'b00, 32'h0F0F0F0F};
    vt[12] = '{1'b0, 14'd2000, 32'h00000000, 39'd0,                          2'b00, 2'b11, 32'h00000000};

    repeat (2) @(negedge clk);
    chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("rst_wr_resp", {30'd0, bus.wr_resp}, 32'd0);
    chk("rst_rd_resp", {30'd0, bus.rd_resp}, 32'd0);
    chk("rst_data_out", bus.ECC_ctrl_data_out, 32'd0);
    chk("rst_sbe", {16'd0, bus.sbe_count}, 32'd0);
    chk("rst_dbe", {16'd0, bus.dbe_count}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      if (vt[i].do_wr) do_wr(vt[i].addr, vt[i].data, vt[i].exp_wr);
      if (vt[i].flip != 39'd0) corrupt(int'(vt[i].addr), vt[i].flip);
      do_rd(vt[i].addr, vt[i].exp_d, vt[i].exp_rr);
      drain();
    end

    // Corrected read followed by a second read of the same word.
    do_wr(14'd5, 32'hDEADBEEF, 2'b00);
    corrupt(5, (39'd1 << 7));
    do_rd(14'd5, 32'hDEADBEEF, 2'b01);
    drain();
    repeat (2) @(negedge clk);
`ifdef ECC_MEM_CTRL_SCRUB_EN
    do_rd(14'd5, 32'hDEADBEEF, 2'b00);
`else
    do_rd(14'd5, 32'hDEADBEEF, 2'b01);
`endif
    drain();

    // Read and write of the same address in one cycle.
    do_wr(14'd3, 32'h00000001, 2'b00);
    @(negedge clk);
    bus.ECC_ctrl_wr_en = 1'b1;
    bus.ECC_ctrl_wr_addr_bus = 14'd3;
    bus.ECC_ctrl_write_data_bus = 32'h00000002;
    bus.ECC_ctrl_rd_en = 1'b1;
    bus.ECC_ctrl_rd_addr_bus = 14'd3;
    q.push_back('{data: 32'h00000001, resp: 2'b00, cyc: cyc});
    @(negedge clk);
    bus.ECC_ctrl_wr_en = 1'b0;
    bus.ECC_ctrl_rd_en = 1'b0;
    chk("rbw_wr_resp", {30'd0, bus.wr_resp}, 32'd0);
    do_rd(14'd3, 32'h00000002, 2'b00);
    drain();

    // Back-to-back reads, one per cycle.
    begin
      logic [13:0] ba [4];
      logic [31:0] bd [4];
      logic [1:0]  br [4];
      ba = '{14'd1023, 14'd0, 14'd3, 14'd2000};
      bd = '{32'hA5A5A5A5, 32'h0F0F0F0F, 32'h00000002, 32'h00000000};
      br = '{2'b00, 2'b00, 2'b00, 2'b11};
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        bus.ECC_ctrl_rd_en = 1'b1;
        bus.ECC_ctrl_rd_addr_bus = ba[i];
        q.push_back('{data: bd[i], resp: br[i], cyc: cyc});
      end
      @(negedge clk);
      bus.ECC_ctrl_rd_en = 1'b0;
      drain();
    end

    // Single-bit error counter saturation.
    @(negedge clk);
    u_dut.r_sbe_count = 16'hFFFE;
    exp_sbe = 16'hFFFE;
    for (int i = 0; i < 2; i++) begin
      do_wr(14'd14, 32'h12345678, 2'b00);
      corrupt(14, (39'd1 << 38));
      do_rd(14'd14, 32'h12345678, 2'b01);
      drain();
    end
    chk("sbe_saturated", {16'd0, bus.sbe_count}, 32'h0000FFFF);

    // Reads on four consecutive cycles with reset from the third onward.
    @(negedge clk);
    bus.ECC_ctrl_rd_en = 1'b1;
    bus.ECC_ctrl_rd_addr_bus = 14'd1023;
    q.push_back('{data: 32'hA5A5A5A5, resp: 2'b00, cyc: cyc});
    @(negedge clk);
    bus.ECC_ctrl_rd_addr_bus = 14'd0;
    @(negedge clk);
    reset = 1'b1;
    bus.ECC_ctrl_rd_addr_bus = 14'd3;
    @(negedge clk);
    bus.ECC_ctrl_rd_addr_bus = 14'd1023;
    exp_sbe = 16'd0;
    exp_dbe = 16'd0;
    chk("rrst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("rrst_data_out", bus.ECC_ctrl_data_out, 32'd0);
    chk("rrst_rd_resp", {30'd0, bus.rd_resp}, 32'd0);
    chk("rrst_wr_resp", {30'd0, bus.wr_resp}, 32'd0);
    chk("rrst_sbe", {16'd0, bus.sbe_count}, 32'd0);
    chk("rrst_dbe", {16'd0, bus.dbe_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.ECC_ctrl_rd_en = 1'b0;
    repeat (6) @(negedge clk);
    chk("rrst_queue_empty", 32'(q.size()), 32'd0);
    chk("rrst_idle_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("rrst_idle_data", bus.ECC_ctrl_data_out, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ecc_mem_ctrl.md
ECC_MEM_CTRL -- requirements
Module: ecc_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width; only 32 is supported.
REQ-002 SHALL have parameter MEM_CTRL_ADDR_WIDTH, default 14, address bus width.
REQ-003 SHALL have parameter EXT_MEM_DEPTH, default 1024, number of stored words.
REQ-004 SHALL have one clock, clk; reset is synchronous and active-high, port reset.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 ECC_ctrl_wr_en  input  1  write request, one word per cycle.
REQ-008 ECC_ctrl_wr_addr_bus  input  MEM_CTRL_ADDR_WIDTH  write address.
REQ-009 ECC_ctrl_write_data_bus  input  DATA_WIDTH  write data.
REQ-010 wr_resp  output  2  write response for the previous cycle's write.
REQ-011 ECC_ctrl_rd_en  input  1  read request, one per cycle.
REQ-012 ECC_ctrl_rd_addr_bus  input  MEM_CTRL_ADDR_WIDTH  read address.
REQ-013 ECC_ctrl_data_out  output  DATA_WIDTH  corrected read data.
REQ-014 rd_valid  output  1  data_out/rd_resp valid this cycle.
REQ-015 rd_resp  output  2  read response qualified by rd_valid.
REQ-016 sbe_count  output  16  corrected single-bit error count.
REQ-017 dbe_count  output  16  uncorrectable double-bit error count.

Function
REQ-018 Write: SECDED encode (Hamming(38,32) + overall parity = 39-bit codeword) and store at addr in the cycle wr_en is sampled.
REQ-019 wr_resp SHALL be 2'b00 (OKAY) one cycle after an in-range write, 2'b11 (SLVERR) after addr >= EXT_MEM_DEPTH with no array write, else 2'b00.
REQ-020 Read latency SHALL be 2 cycles: rd_en at cycle N -> rd_valid, data_out, rd_resp at N+2; fully pipelined, back-to-back reads every cycle.
REQ-021 rd_resp SHALL be 00 no error, 01 single-bit corrected (data_out corrected), 10 double-bit detected (data_out = raw data bits), 11 read addr out of range (data_out = 0).
REQ-022 Error in the overall parity bit only SHALL report 01 with data unchanged.
REQ-023 Simultaneous read and write of the same address SHALL return the old word (read-before-write).
REQ-024 sbe_count/dbe_count SHALL increment by 1 per 01/10 response and saturate at 16'hFFFF.
REQ-025 data_out and rd_resp SHALL hold their last values when rd_valid is 0.

Reset
REQ-026 reset SHALL clear rd_valid, wr_resp, rd_resp, data_out, both counters, pipeline registers and scrub state to 0 on the next clock edge.
REQ-027 Array contents SHALL NOT be reset; reads in flight during reset SHALL be discarded (no rd_valid).

Configuration
REQ-028 Macro ECC_MEM_CTRL_SCRUB_EN, when defined, SHALL write the corrected codeword back to the address of every rd_resp=01 read.
REQ-029 Scrub write SHALL occur in the first cycle with ECC_ctrl_wr_en=0 (external write has priority); one-entry pending buffer; a new correctable error while pending SHALL replace the entry.
REQ-030 A pending scrub SHALL be cancelled if an external write targets the same address.
REQ-031 Without the macro, no write-back logic SHALL exist and the array is written only by external writes.

Structure
REQ-032 Package ecc_mem_pkg SHALL hold CW_WIDTH=39, the response enum (RESP_OKAY, RESP_CORR, RESP_UNCORR, RESP_SLVERR) and the secded_encode function.
REQ-033 Syndrome decode/correct SHALL be sub-module secded_decoder (combinational, 39-bit in, 32-bit data + 2-bit status out), instantiated in pipeline stage 2.

Verification
REQ-034 Write 32'hDEADBEEF to addr 5, read addr 5 -> rd_valid 2 cycles later, data_out 32'hDEADBEEF, rd_resp 00.
REQ-035 Force bit 7 of stored codeword at addr 5, read -> data_out 32'hDEADBEEF, rd_resp 01, sbe_count 1; with SCRUB_EN, second read -> rd_resp 00.
REQ-036 Force bits 3 and 20 at addr 9, read -> rd_resp 10, dbe_count 1, sbe_count unchanged.
REQ-037 Write addr 1024, read addr 2000 -> wr_resp 11 next cycle, no array change; rd_resp 11, data_out 0.
REQ-038 Same-cycle read+write addr 3 (old 32'h1, new 32'h2) -> data_out 32'h1; next read -> 32'h2.
REQ-039 Issue reads on 4 consecutive cycles, assert reset in the 3rd -> no rd_valid after reset, all outputs 0.
